// File: rtl/ks_sum_stage.sv
// ks_sum_stage: registered sum stage of the Kogge-Stone adder, 2-entry skid.
// Define KS_SAT_EN to saturate the stored sum on signed overflow.
module ks_sum_stage #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_c0,
    input  logic [W-1:0] i_gk,
    input  logic [W-1:0] i_p_save,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf,
    output logic         o_busy
);

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    res_t   main_q, main_d;
    res_t   skid_q, skid_d;
    res_t   res;

    logic [W-1:0] carry_in;
    logic         accept;
    logic         drain;

    // Carry into bit k is the group generate of bit k-1; bit 0 takes c0.
    assign carry_in = {i_gk[W-2:0], i_c0};

    always_comb begin
        res.sum  = i_p_save ^ carry_in;
        res.cout = i_gk[W-1];
        res.ovf  = i_gk[W-1] ^ i_gk[W-2];
`ifdef KS_SAT_EN
        if (res.ovf) begin
            res.sum = res.cout ? {1'b1, {(W-1){1'b0}}}
                               : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    assign o_ready = (state_q != FULL);
    assign o_valid = (state_q != EMPTY);
    assign o_busy  = (state_q != EMPTY);
    assign o_sum   = main_q.sum;
    assign o_cout  = main_q.cout;
    assign o_ovf   = main_q.ovf;

    assign accept = i_valid & o_ready;
    assign drain  = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = res;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = res;
                end else if (accept) begin
                    skid_d  = res;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Skid is always older than any new input: it moves up first.
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_ks_sum_stage.sv
// tb_ks_sum_stage: directed table, back-pressure, streaming and reset checks.
// Expected sums follow the KS_SAT_EN setting of the build.
module tb_ks_sum_stage;

    localparam int W = 32;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic         i_c0;
    logic [W-1:0] i_gk;
    logic [W-1:0] i_p_save;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_ovf;
    logic         o_busy;

    int n_run;
    int n_fail;

    ks_sum_stage #(.W(W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_c0     (i_c0),
        .i_gk     (i_gk),
        .i_p_save (i_p_save),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_cout   (o_cout),
        .o_ovf    (o_ovf),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        logic [31:0] s_wrap;
        logic [31:0] s_sat;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Ripple reference for the prefix network outputs feeding the stage.
    task automatic mk(input logic [31:0] a, input logic [31:0] b,
                      input logic c0, output logic [31:0] gk,
                      output logic [31:0] p);
        logic c;
        c = c0;
        p = a ^ b;
        for (int k = 0; k < W; k++) begin
            gk[k] = (a[k] & b[k]) | (p[k] & c);
            c = gk[k];
        end
    endtask

    function automatic logic [33:0] ref_res(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic c0);
        logic [32:0] t;
        logic        ovf;
        logic [31:0] s;
        t = {1'b0, a} + {1'b0, b} + {32'd0, c0};
        s = t[31:0];
        ovf = (a[31] == b[31]) && (s[31] != a[31]);
`ifdef KS_SAT_EN
        if (ovf) s = t[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {s, t[32], ovf};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic c0, input logic v);
        logic [31:0] gk;
        logic [31:0] p;
        mk(a, b, c0, gk, p);
        i_gk     = gk;
        i_p_save = p;
        i_c0     = c0;
        i_valid  = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [33:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [33:0] e;
        logic [31:0] s_exp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        acc;

        n_run  = 0;
        n_fail = 0;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 1'b0,
                    32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
                    32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
                    32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0,
                    32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0,
                    32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0,
                    32'h2345_6789, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                    32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};

        i_rst_n = 1'b0;
        i_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_data", {31'd0, o_sum, o_cout, o_ovf}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed table, back to back with i_ready high.
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].c0, 1'b1);
            @(posedge i_clk);
            #1;
`ifdef KS_SAT_EN
            s_exp = vecs[i].s_sat;
`else
            s_exp = vecs[i].s_wrap;
`endif
            chk($sformatf("tbl%0d_valid", i), {63'd0, o_valid}, 64'd1);
            chk($sformatf("tbl%0d_sum", i), {32'd0, o_sum}, {32'd0, s_exp});
            chk($sformatf("tbl%0d_cout", i), {63'd0, o_cout},
                {63'd0, vecs[i].cout});
            chk($sformatf("tbl%0d_ovf", i), {63'd0, o_ovf},
                {63'd0, vecs[i].ovf});
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("tbl_drain_valid", {63'd0, o_valid}, 64'd0);
        chk("tbl_drain_busy", {63'd0, o_busy}, 64'd0);

        // Back-pressure: two accepts fill the stage, third op stalls.
        @(negedge i_clk);
        i_ready = 1'b0;
        drive(32'd1, 32'd1, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        chk("bp_lat_valid", {63'd0, o_valid}, 64'd1);
        @(negedge i_clk);
        drive(32'd2, 32'd2, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        chk("bp_full_ready", {63'd0, o_ready}, 64'd0);
        @(negedge i_clk);
        drive(32'd3, 32'd3, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        chk("bp_stall_ready", {63'd0, o_ready}, 64'd0);
        chk("bp_stable_sum", {32'd0, o_sum}, 64'd2);
        chk("bp_busy", {63'd0, o_busy}, 64'd1);
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_valid) got_q.push_back(o_sum);
            acc = o_ready & i_valid;
            @(posedge i_clk);
            #1;
            if (acc) i_valid = 1'b0;
        end
        chk("bp_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("bp_out0", {32'd0, got_q[0]}, 64'd2);
            chk("bp_out1", {32'd0, got_q[1]}, 64'd4);
            chk("bp_out2", {32'd0, got_q[2]}, 64'd6);
        end

        // Streaming: one op per cycle against the reference model.
        for (int i = 0; i <= 100; i++) begin
            @(negedge i_clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("st%0d_valid", i - 1), {63'd0, o_valid}, 64'd1);
                chk($sformatf("st%0d_ready", i - 1), {63'd0, o_ready}, 64'd1);
                chk($sformatf("st%0d_data", i - 1),
                    {30'd0, o_sum, o_cout, o_ovf}, {30'd0, e});
            end
            if (i < 100) begin
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
                exp_q.push_back(ref_res(ra, rb, rc));
                drive(ra, rb, rc, 1'b1);
            end else begin
                i_valid = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;

        // Reset while FULL discards both entries at once.
        i_ready = 1'b0;
        @(negedge i_clk);
        drive(32'd5, 32'd5, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        drive(32'd6, 32'd6, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        chk("rf_full_ready", {63'd0, o_ready}, 64'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rf_valid", {63'd0, o_valid}, 64'd0);
        chk("rf_ready", {63'd0, o_ready}, 64'd1);
        chk("rf_busy", {63'd0, o_busy}, 64'd0);
        chk("rf_data", {31'd0, o_sum, o_cout, o_ovf}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("rf_post%0d_valid", c), {63'd0, o_valid}, 64'd0);
            chk($sformatf("rf_post%0d_ready", c), {63'd0, o_ready}, 64'd1);
        end
        @(negedge i_clk);
        drive(32'd9, 32'd9, 1'b0, 1'b1);
        @(posedge i_clk);
        #1;
        chk("rf_after_valid", {63'd0, o_valid}, 64'd1);
        chk("rf_after_sum", {32'd0, o_sum}, 64'd18);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
